// File: rtl/store_formatter_if.sv
// Store request and data-memory write bus for store_formatter.
// master = execute stage plus memory environment, slave = the formatter itself.
interface store_formatter_if #(
  parameter int AW = 32
);
  logic          st_valid;
  logic          st_ready;
  logic [4:0]    opcode;
  logic [2:0]    funct3;
  logic [AW-1:0] addr;
  logic [31:0]   rs2_data;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_strb;
  logic          st_err;
  logic          buf_empty;

  modport master (
    output st_valid, opcode, funct3, addr, rs2_data, mem_ready,
    input  st_ready, mem_valid, mem_addr, mem_wdata, mem_strb, st_err, buf_empty
  );

  modport slave (
    input  st_valid, opcode, funct3, addr, rs2_data, mem_ready,
    output st_ready, mem_valid, mem_addr, mem_wdata, mem_strb, st_err, buf_empty
  );
endinterface

// File: rtl/store_formatter.sv
// Store formatter: turns execute-stage stores into lane-replicated write data and
// byte strobes, buffered in an in-order FIFO. Define STORE_FORMATTER_CNT_EN for wr_count.
module store_formatter #(
  parameter int DEPTH = 2,
  parameter int AW    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  store_formatter_if.slave bus
`ifdef STORE_FORMATTER_CNT_EN
  ,
  output logic [31:0] wr_count
`endif
);

  localparam int             PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int             CW       = PW + 1;
  localparam logic [CW-1:0]  FULL     = CW'(DEPTH);
  localparam logic [4:0]     OP_STORE = 5'b01000;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_ILLEG = 2'd3
  } size_t;

  // Only the word address is stored; the byte offset is folded into the strobe.
  logic [AW-3:0] q_addr  [DEPTH];
  logic [31:0]   q_wdata [DEPTH];
  logic [3:0]    q_strb  [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          st_err_q;

  logic          ready;
  logic          has_entry;
  logic          accept;
  logic          is_store;
  logic          misaligned;
  logic          push;
  logic          pop;
  logic          err_next;
  size_t         size;
  logic [31:0]   fmt_wdata;
  logic [3:0]    fmt_strb;

  assign ready     = (count != FULL);
  assign has_entry = (count != '0);
  assign accept    = bus.st_valid & ready;
  assign pop       = has_entry & bus.mem_ready;
  assign is_store  = (bus.opcode == OP_STORE);

  always_comb begin
    size       = SZ_ILLEG;
    misaligned = 1'b0;
    fmt_wdata  = '0;
    fmt_strb   = '0;
    case (bus.funct3)
      3'b000: begin
        size      = SZ_BYTE;
        fmt_wdata = {4{bus.rs2_data[7:0]}};
        fmt_strb  = 4'b0001 << bus.addr[1:0];
      end
      3'b001: begin
        size       = SZ_HALF;
        misaligned = bus.addr[0];
        fmt_wdata  = {2{bus.rs2_data[15:0]}};
        fmt_strb   = 4'b0011 << {bus.addr[1], 1'b0};
      end
      3'b010: begin
        size       = SZ_WORD;
        misaligned = (bus.addr[1:0] != 2'b00);
        fmt_wdata  = bus.rs2_data;
        fmt_strb   = 4'b1111;
      end
      default: begin
        size = SZ_ILLEG;
      end
    endcase
  end

  // Non-store opcodes are consumed silently; bad stores are consumed and flagged.
  assign push     = accept & is_store & (size != SZ_ILLEG) & ~misaligned;
  assign err_next = accept & is_store & ((size == SZ_ILLEG) | misaligned);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      st_err_q <= 1'b0;
    end else begin
      st_err_q <= err_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Payload storage needs no reset: outputs are masked whenever count is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr]  <= bus.addr[AW-1:2];
      q_wdata[wr_ptr] <= fmt_wdata;
      q_strb[wr_ptr]  <= fmt_strb;
    end
  end

`ifdef STORE_FORMATTER_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count <= '0;
    end else if (pop) begin
      wr_count <= wr_count + 32'd1;
    end
  end
`endif

  assign bus.st_ready  = ready;
  assign bus.mem_valid = has_entry;
  assign bus.buf_empty = ~has_entry;
  assign bus.st_err    = st_err_q;
  assign bus.mem_addr  = has_entry ? {q_addr[rd_ptr], 2'b00} : '0;
  assign bus.mem_wdata = has_entry ? q_wdata[rd_ptr] : '0;
  assign bus.mem_strb  = has_entry ? q_strb[rd_ptr] : '0;

endmodule

// File: tb/tb_store_formatter.sv
// Self-checking bench for store_formatter: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_store_formatter;
  localparam int DEPTH = 2;
  localparam int AW    = 32;
  localparam logic [4:0] OP_ST = 5'b01000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  store_formatter_if #(.AW(AW)) bus ();
`ifdef STORE_FORMATTER_CNT_EN
  logic [31:0] wr_count;
`endif

  store_formatter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef STORE_FORMATTER_CNT_EN
    ,
    .wr_count (wr_count)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } entry_t;

  entry_t      mq[$];
  logic        exp_err = 1'b0;
  logic [31:0] exp_cnt = '0;
  int          checks  = 0;
  int          errors  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] op, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] d, input logic mr);
    bus.st_valid  = v;
    bus.opcode    = op;
    bus.funct3    = f3;
    bus.addr      = a;
    bus.rs2_data  = d;
    bus.mem_ready = mr;
  endtask

  // Reference formatting written from the lane rules with plain arithmetic.
  function automatic entry_t formatEntry(input int f, input logic [31:0] a, input logic [31:0] d);
    entry_t e;
    e.addr = a - (a % 4);
    case (f)
      0: begin
        e.wdata = (d & 32'hFF) * 32'h0101_0101;
        e.strb  = 4'(1 << (a % 4));
      end
      1: begin
        e.wdata = (d & 32'hFFFF) * 32'h0001_0001;
        e.strb  = 4'(3 << (a % 4));
      end
      default: begin
        e.wdata = d;
        e.strb  = 4'hF;
      end
    endcase
    return e;
  endfunction

  task automatic checkAll(input string pfx);
    checkOutput({pfx, "st_ready"},  32'(bus.st_ready),  32'(mq.size() != DEPTH));
    checkOutput({pfx, "mem_valid"}, 32'(bus.mem_valid), 32'(mq.size() != 0));
    checkOutput({pfx, "buf_empty"}, 32'(bus.buf_empty), 32'(mq.size() == 0));
    checkOutput({pfx, "st_err"},    32'(bus.st_err),    32'(exp_err));
    if (mq.size() != 0) begin
      checkOutput({pfx, "mem_addr"},  bus.mem_addr,       mq[0].addr);
      checkOutput({pfx, "mem_wdata"}, bus.mem_wdata,      mq[0].wdata);
      checkOutput({pfx, "mem_strb"},  32'(bus.mem_strb),  32'(mq[0].strb));
    end else begin
      checkOutput({pfx, "mem_addr0"},  bus.mem_addr,      32'h0);
      checkOutput({pfx, "mem_wdata0"}, bus.mem_wdata,     32'h0);
      checkOutput({pfx, "mem_strb0"},  32'(bus.mem_strb), 32'h0);
    end
`ifdef STORE_FORMATTER_CNT_EN
    checkOutput({pfx, "wr_count"}, wr_count, exp_cnt);
`endif
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic modelStep();
    logic        acc;
    logic        pop;
    logic        st;
    logic        legal;
    logic        aligned;
    int          f;
    logic [31:0] a;
    f       = int'(bus.funct3);
    a       = bus.addr;
    acc     = bus.st_valid && (mq.size() != DEPTH);
    pop     = (mq.size() != 0) && bus.mem_ready;
    st      = (bus.opcode == OP_ST);
    legal   = (f <= 2);
    aligned = (f == 0) || (f == 1 && a % 2 == 0) || (f == 2 && a % 4 == 0);
    exp_err = acc && st && !(legal && aligned);
    if (pop) begin
      void'(mq.pop_front());
      exp_cnt = exp_cnt + 32'd1;
    end
    if (acc && st && legal && aligned) mq.push_back(formatEntry(f, a, bus.rs2_data));
  endtask

  task automatic step();
    @(negedge clk);
    checkAll("");
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic mr, input int n);
    applyStimulus(1'b0, 5'b0, 3'b0, 32'h0, 32'h0, mr);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic held;
    applyStimulus(1'b0, 5'b0, 3'b0, 32'h0, 32'h0, 1'b0);
    #12;
    checkAll("reset_");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // SB to the top byte lane, popped straight away
    applyStimulus(1'b1, OP_ST, 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 1'b1);
    step();
    checkOutput("sb_valid", 32'(bus.mem_valid), 32'h1);
    checkOutput("sb_addr",  bus.mem_addr,       32'h0000_1000);
    checkOutput("sb_wdata", bus.mem_wdata,      32'hDDDD_DDDD);
    checkOutput("sb_strb",  32'(bus.mem_strb),  32'h8);
    idle(1'b1, 1);
    checkOutput("sb_empty", 32'(bus.buf_empty), 32'h1);

    // SH upper half then SW back to back
    applyStimulus(1'b1, OP_ST, 3'b001, 32'h0000_2002, 32'h1234_5678, 1'b1);
    step();
    checkOutput("sh_addr",  bus.mem_addr,      32'h0000_2000);
    checkOutput("sh_wdata", bus.mem_wdata,     32'h5678_5678);
    checkOutput("sh_strb",  32'(bus.mem_strb), 32'hC);
    applyStimulus(1'b1, OP_ST, 3'b010, 32'h0000_2004, 32'hCAFE_F00D, 1'b1);
    step();
    checkOutput("sw_wdata", bus.mem_wdata,     32'hCAFE_F00D);
    checkOutput("sw_strb",  32'(bus.mem_strb), 32'hF);
    idle(1'b1, 2);

    // Misaligned and illegal stores: one error pulse each, nothing buffered
    applyStimulus(1'b1, OP_ST, 3'b010, 32'h0000_3001, 32'h1, 1'b1);
    step();
    checkOutput("err_sw", 32'(bus.st_err), 32'h1);
    applyStimulus(1'b1, OP_ST, 3'b001, 32'h0000_3003, 32'h2, 1'b1);
    step();
    checkOutput("err_sh", 32'(bus.st_err), 32'h1);
    applyStimulus(1'b1, OP_ST, 3'b011, 32'h0000_3000, 32'h3, 1'b1);
    step();
    checkOutput("err_f3", 32'(bus.st_err), 32'h1);
    checkOutput("err_empty", 32'(bus.buf_empty), 32'h1);
    idle(1'b1, 1);
    checkOutput("err_clear", 32'(bus.st_err), 32'h0);

    // Backpressure: fill the FIFO, hold a third request, then drain in order
    applyStimulus(1'b1, OP_ST, 3'b000, 32'h10, 32'h11, 1'b0);
    step();
    applyStimulus(1'b1, OP_ST, 3'b001, 32'h20, 32'h2222, 1'b0);
    step();
    checkOutput("full_ready", 32'(bus.st_ready), 32'h0);
    applyStimulus(1'b1, OP_ST, 3'b010, 32'h30, 32'h3333_3333, 1'b0);
    step();
    step();
    checkOutput("held_head", bus.mem_addr, 32'h10);
    bus.mem_ready = 1'b1;
    held = 1'b1;
    for (int i = 0; i < 8 && held; i++) begin
      held = (mq.size() == DEPTH);
      step();
    end
    checkOutput("third_accepted", 32'(held), 32'h0);
    idle(1'b1, 3);

    // Asynchronous reset with two entries pending
    applyStimulus(1'b1, OP_ST, 3'b000, 32'h40, 32'h44, 1'b0);
    step();
    applyStimulus(1'b1, OP_ST, 3'b010, 32'h44, 32'h4444_4444, 1'b0);
    step();
    applyStimulus(1'b0, 5'b0, 3'b0, 32'h0, 32'h0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    mq.delete();
    exp_err = 1'b0;
    exp_cnt = '0;
    checkOutput("rst_valid", 32'(bus.mem_valid), 32'h0);
    checkOutput("rst_empty", 32'(bus.buf_empty), 32'h1);
    checkOutput("rst_ready", 32'(bus.st_ready),  32'h1);
    checkOutput("rst_addr",  bus.mem_addr,       32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(1'b1, 3);

    // Non-store opcode is consumed without effect
    applyStimulus(1'b1, 5'b00000, 3'b010, 32'h50, 32'h5, 1'b1);
    checkOutput("nonst_ready", 32'(bus.st_ready), 32'h1);
    step();
    checkOutput("nonst_empty", 32'(bus.buf_empty), 32'h1);
    checkOutput("nonst_err",   32'(bus.st_err),    32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, OP_ST, 3'b010, 32'h60 + 32'(4 * i), 32'h600 + 32'(i), 1'b1);
      step();
    end
    idle(1'b1, 2);
`ifdef STORE_FORMATTER_CNT_EN
    checkOutput("cnt_three", wr_count, 32'd3);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [4:0]  op;
      logic [2:0]  f3;
      logic [31:0] a;
      op = ($urandom_range(0, 4) == 0) ? 5'($urandom) : OP_ST;
      f3 = ($urandom_range(0, 7) < 6) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
      a  = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      applyStimulus(1'($urandom_range(0, 3) != 0), op, f3, a, $urandom,
                    1'($urandom_range(0, 2) != 0));
      step();
    end
    idle(1'b1, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end
endmodule
